// File: rtl/uart_rx_ctrl.sv
// APB UART receive controller: FIFO/holding-register sequencing, LSR RX bits, RX interrupts.
// Optional character-timeout counter enabled by defining UART_RX_TIMEOUT_EN.
module uart_rx_ctrl #(
  parameter int FIFO_AW = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RXCLK,
  input  logic               RXFINISHED,
  input  logic [7:0]         DOUT,
  input  logic               PE,
  input  logic               FE,
  input  logic               BI,
  input  logic [1:0]         WLS,
  input  logic               STB,
  input  logic               PEN,
  input  logic               FIFO_EN,
  input  logic               FIFO_RST,
  input  logic [1:0]         TRIG,
  input  logic               RBR_READ,
  input  logic               LSR_READ,
  input  logic               RXF_EMPTY,
  input  logic               RXF_FULL,
  input  logic [FIFO_AW:0]   RXF_USAGE,
  input  logic [10:0]        RXF_RDATA,
  output logic               RXF_WRITE,
  output logic [10:0]        RXF_WDATA,
  output logic               RXF_READ,
  output logic               RXF_CLEAR,
  output logic [7:0]         RBR,
  output logic               DR,
  output logic               OE,
  output logic               LSR_PE,
  output logic               LSR_FE,
  output logic               LSR_BI,
  output logic               LSR_ERR,
  output logic               RDA_INT,
  output logic               CTO_INT
);
  localparam int CW = FIFO_AW + 1;

  typedef enum logic {IDLE, PUSH} state_t;

  state_t        state_q, state_d;
  logic [10:0]   wdata_q, wdata_d;
  logic [7:0]    hold_q, hold_d;
  logic          dr_q, dr_d;
  logic          oe_q, oe_d;
  logic          en_q, en_d;
  logic          clr_q, clr_d;
  logic [2:0]    flg_q, flg_d, flg_set;
  logic [CW-1:0] err_q, err_d, trig_lvl;
  logic          push, wr, rd, inc, dec, oe_set;

  assign push = (state_q == PUSH);
  assign wr   = push & FIFO_EN & ~RXF_FULL;
  assign rd   = FIFO_EN & RBR_READ & ~RXF_EMPTY;
  assign inc  = wr & (|wdata_q[10:8]);
  assign dec  = rd & (|RXF_RDATA[10:8]);

  always_comb begin
    state_d = IDLE;
    wdata_d = wdata_q;
    if (!push && RXFINISHED) begin
      state_d = PUSH;
      wdata_d = {BI, FE, PE, DOUT};
    end
    hold_d = hold_q;
    dr_d   = dr_q;
    if (!FIFO_EN && RBR_READ) dr_d = 1'b0;
    if (push && !FIFO_EN) begin
      hold_d = wdata_q[7:0];
      dr_d   = 1'b1;
    end
    if (clr_q) begin
      hold_d = 8'h00;
      dr_d   = 1'b0;
    end
    // Overrun: lost in PUSH, FIFO full, or holding register still unread
    oe_set = push & (RXFINISHED | (FIFO_EN & RXF_FULL) | (~FIFO_EN & dr_q));
    oe_d   = oe_set | (oe_q & ~LSR_READ);
    if (FIFO_EN) flg_set = RXF_EMPTY ? 3'b000 : RXF_RDATA[10:8];
    else         flg_set = push ? wdata_q[10:8] : 3'b000;
    flg_d = flg_set | (flg_q & {3{~LSR_READ}});
    err_d = clr_q ? '0 : err_q + CW'(inc) - CW'(dec);
    en_d  = FIFO_EN;
    clr_d = FIFO_RST | (FIFO_EN ^ en_q);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      wdata_q <= '0;
      hold_q  <= '0;
      dr_q    <= 1'b0;
      oe_q    <= 1'b0;
      flg_q   <= '0;
      err_q   <= '0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      dr_q    <= dr_d;
      oe_q    <= oe_d;
      flg_q   <= flg_d;
      err_q   <= err_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    trig_lvl = CW'(1);
    unique case (TRIG)
      2'b00: trig_lvl = CW'(1);
      2'b01: trig_lvl = CW'(4);
      2'b10: trig_lvl = CW'(8);
      2'b11: trig_lvl = CW'(14);
    endcase
  end

  assign RXF_WRITE = wr;
  assign RXF_WDATA = wdata_q;
  assign RXF_READ  = rd;
  assign RXF_CLEAR = clr_q;
  assign RBR       = FIFO_EN ? RXF_RDATA[7:0] : hold_q;
  assign DR        = FIFO_EN ? ~RXF_EMPTY : dr_q;
  assign OE        = oe_q;
  assign LSR_PE    = flg_q[0];
  assign LSR_FE    = flg_q[1];
  assign LSR_BI    = flg_q[2];
  assign LSR_ERR   = FIFO_EN & (err_q != '0);
  assign RDA_INT   = FIFO_EN ? (RXF_USAGE >= trig_lvl) : dr_q;

`ifdef UART_RX_TIMEOUT_EN
  logic [9:0] tmo_q, tmo_d, tmo_lim;
  logic [3:0] bits;

  // start + data + parity + stop(s)
  assign bits    = 4'd7 + {2'b00, WLS} + {3'b000, PEN} + {3'b000, STB};
  assign tmo_lim = {bits, 6'b000000};

  always_comb begin
    tmo_d = tmo_q;
    if (wr || rd || RXF_EMPTY || !FIFO_EN || clr_q) tmo_d = '0;
    else if (RXCLK && tmo_q < tmo_lim) tmo_d = tmo_q + 10'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end

  assign CTO_INT = (tmo_q >= tmo_lim);
`else
  logic unused_tmo;
  assign unused_tmo = ^{RXCLK, WLS, STB, PEN};
  assign CTO_INT = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized bench for uart_rx_ctrl with a queue-based FIFO and an LSR/interrupt model.
// Defining UART_RX_TIMEOUT_EN also checks the character-timeout interrupt.
module tb_uart_rx_ctrl;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic RXCLK = 1'b0, RXFINISHED = 1'b0;
  logic [7:0] DOUT = '0;
  logic PE = 1'b0, FE = 1'b0, BI = 1'b0;
  logic [1:0] WLS = '0;
  logic STB = 1'b0, PEN = 1'b0;
  logic FIFO_EN = 1'b0, FIFO_RST = 1'b0;
  logic [1:0] TRIG = '0;
  logic RBR_READ = 1'b0, LSR_READ = 1'b0;
  logic RXF_EMPTY = 1'b1, RXF_FULL = 1'b0;
  logic [AW:0] RXF_USAGE = '0;
  logic [10:0] RXF_RDATA = '0;
  logic RXF_WRITE, RXF_READ, RXF_CLEAR;
  logic [10:0] RXF_WDATA;
  logic [7:0] RBR;
  logic DR, OE, LSR_PE, LSR_FE, LSR_BI, LSR_ERR, RDA_INT, CTO_INT;

  always #5 CLK = ~CLK;

  uart_rx_ctrl #(.FIFO_AW(AW)) dut (
    .CLK(CLK), .RST(RST), .RXCLK(RXCLK), .RXFINISHED(RXFINISHED),
    .DOUT(DOUT), .PE(PE), .FE(FE), .BI(BI),
    .WLS(WLS), .STB(STB), .PEN(PEN),
    .FIFO_EN(FIFO_EN), .FIFO_RST(FIFO_RST), .TRIG(TRIG),
    .RBR_READ(RBR_READ), .LSR_READ(LSR_READ),
    .RXF_EMPTY(RXF_EMPTY), .RXF_FULL(RXF_FULL),
    .RXF_USAGE(RXF_USAGE), .RXF_RDATA(RXF_RDATA),
    .RXF_WRITE(RXF_WRITE), .RXF_WDATA(RXF_WDATA),
    .RXF_READ(RXF_READ), .RXF_CLEAR(RXF_CLEAR),
    .RBR(RBR), .DR(DR), .OE(OE),
    .LSR_PE(LSR_PE), .LSR_FE(LSR_FE), .LSR_BI(LSR_BI),
    .LSR_ERR(LSR_ERR), .RDA_INT(RDA_INT), .CTO_INT(CTO_INT)
  );

  int n_chk = 0;
  int n_fail = 0;

  int p_fin, p_rd, p_lsr, p_clk, p_rst, p_flg;
  bit cur_en;
  logic [1:0] cur_trig, cur_wls;
  bit cur_stb, cur_pen;

  logic [10:0] fq[$];
  bit m_pend, m_dr, m_oe, m_clr, m_pen;
  logic [10:0] m_ent;
  logic [7:0] m_hold;
  logic [2:0] m_flg;
  int m_tmo;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    m_pend = 0; m_ent = '0; m_hold = '0; m_dr = 0; m_oe = 0;
    m_flg = '0; m_clr = 0; m_pen = 0; m_tmo = 0;
  endtask

  task automatic step(input bit rst);
    int n, lim, lvl;
    bit en, e_wr, e_rd, e_err, e_cto, oe_set, new_pend;
    logic [2:0] fs;
    logic [7:0] e_rbr;
    @(negedge CLK);
    RST = rst;
    if (rst) begin
      RXFINISHED = 0; RBR_READ = 0; LSR_READ = 0; FIFO_RST = 0;
      RXCLK = 0; FIFO_EN = 0; cur_en = 0;
      model_reset();
    end else begin
      RXFINISHED = ($urandom_range(99) < p_fin);
      DOUT = 8'($urandom);
      {BI, FE, PE} = ($urandom_range(99) < p_flg) ? 3'($urandom) : 3'b000;
      RBR_READ = ($urandom_range(99) < p_rd);
      LSR_READ = ($urandom_range(99) < p_lsr);
      RXCLK = ($urandom_range(99) < p_clk);
      FIFO_RST = ($urandom_range(999) < p_rst);
      FIFO_EN = cur_en;
    end
    TRIG = cur_trig; WLS = cur_wls; STB = cur_stb; PEN = cur_pen;
    n = fq.size();
    RXF_EMPTY = (n == 0);
    RXF_FULL = (n == DEPTH);
    RXF_USAGE = (AW+1)'(n);
    RXF_RDATA = (n == 0) ? 11'h000 : fq[0];
    #1;
    en = FIFO_EN;
    e_wr = m_pend && en && (n < DEPTH);
    e_rd = en && RBR_READ && (n > 0);
    e_rbr = en ? RXF_RDATA[7:0] : m_hold;
    e_err = 0;
    if (en) foreach (fq[i]) if (fq[i][10:8] != 3'b000) e_err = 1;
    lvl = (TRIG == 2'd0) ? 1 : (TRIG == 2'd1) ? 4 : (TRIG == 2'd2) ? 8 : 14;
    lim = (1 + 5 + int'(WLS) + int'(PEN) + (STB ? 2 : 1)) * 64;
`ifdef UART_RX_TIMEOUT_EN
    e_cto = (m_tmo >= lim);
`else
    e_cto = 0;
`endif
    chk("rxf_write", 32'(RXF_WRITE), 32'(e_wr));
    if (e_wr) chk("rxf_wdata", 32'(RXF_WDATA), 32'(m_ent));
    chk("rxf_read", 32'(RXF_READ), 32'(e_rd));
    chk("rxf_clear", 32'(RXF_CLEAR), 32'(m_clr));
    chk("rbr", 32'(RBR), 32'(e_rbr));
    chk("dr", 32'(DR), 32'(en ? (n > 0) : m_dr));
    chk("oe", 32'(OE), 32'(m_oe));
    chk("lsr_flags", 32'({LSR_BI, LSR_FE, LSR_PE}), 32'(m_flg));
    chk("lsr_err", 32'(LSR_ERR), 32'(e_err));
    chk("rda_int", 32'(RDA_INT), 32'(en ? (n >= lvl) : m_dr));
    chk("cto_int", 32'(CTO_INT), 32'(e_cto));
    if (rst) return;
    oe_set = m_pend && (RXFINISHED || (en && n == DEPTH) || (!en && m_dr));
    fs = en ? RXF_RDATA[10:8] : (m_pend ? m_ent[10:8] : 3'b000);
    m_oe = oe_set || (m_oe && !LSR_READ);
    m_flg = fs | (LSR_READ ? 3'b000 : m_flg);
    if (e_wr || e_rd || n == 0 || !en || m_clr) m_tmo = 0;
    else if (RXCLK && m_tmo < lim) m_tmo++;
    if (m_clr) begin
      m_hold = '0; m_dr = 0;
    end else begin
      if (!en && RBR_READ) m_dr = 0;
      if (m_pend && !en) begin m_hold = m_ent[7:0]; m_dr = 1; end
    end
    if (m_clr) fq.delete();
    else begin
      if (e_rd) void'(fq.pop_front());
      if (e_wr) fq.push_back(m_ent);
    end
    new_pend = RXFINISHED && !m_pend;
    if (new_pend) m_ent = {BI, FE, PE, DOUT};
    m_pend = new_pend;
    m_clr = FIFO_RST || (en != m_pen);
    m_pen = en;
  endtask

  task automatic knobs(input int fin, input int rd, input int lsr,
                       input int ck, input int rs, input int flg);
    p_fin = fin; p_rd = rd; p_lsr = lsr; p_clk = ck; p_rst = rs; p_flg = flg;
  endtask

  initial begin
    cur_en = 0; cur_trig = 2'b01; cur_wls = 2'b11; cur_stb = 0; cur_pen = 0;
    knobs(0, 0, 0, 0, 0, 0);
    model_reset();
    step(1); step(1);
    cur_en = 1;
    knobs(30, 25, 10, 50, 3, 25);
    for (int i = 0; i < 1500; i++) begin
      if (i % 300 == 0) cur_trig = 2'($urandom);
      step(0);
    end
    knobs(50, 2, 5, 50, 0, 25);
    for (int i = 0; i < 400; i++) step(0);
    knobs(0, 40, 20, 50, 0, 0);
    for (int i = 0; i < 100; i++) step(0);
    cur_en = 0;
    knobs(20, 15, 10, 50, 3, 30);
    for (int i = 0; i < 800; i++) step(0);
    cur_en = 1;
    for (int r = 0; r < 3; r++) begin
      cur_wls = (r == 0) ? 2'b11 : 2'($urandom);
      cur_stb = (r == 0) ? 1'b0 : 1'($urandom);
      cur_pen = (r == 0) ? 1'b0 : 1'($urandom);
      knobs(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0);
      knobs(30, 0, 5, 100, 0, 25);
      for (int i = 0; i < 12; i++) step(0);
      knobs(0, 0, 5, 100, 0, 0);
      for (int i = 0; i < 900; i++) step(0);
      knobs(0, 50, 10, 100, 0, 0);
      for (int i = 0; i < 60; i++) step(0);
    end
    knobs(35, 30, 10, 60, 4, 30);
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(99) == 0) cur_en = !cur_en;
      if ($urandom_range(199) == 0) cur_trig = 2'($urandom);
      if ($urandom_range(399) == 0) step(1);
      else step(0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
